// File: rtl/exception_controller_pkg.sv
// Shared definitions for the exception controller: cause codes, CP0 register
// indices and the sequencer state encoding.
`ifndef EXCEPTION_CONTROLLER_DEFINES
`define EXCEPTION_CONTROLLER_DEFINES
`define INT_IRQ     5'd0
`define INT_SYSCALL 5'd8
`define INT_RI      5'd10
`define INT_OVF     5'd12
`define C0_SR       5'd12
`define C0_CAUSE    5'd13
`define C0_EPC      5'd14
`define C0_SR_EC    2
`endif

package exception_controller_pkg;

  localparam int CAUSE_W = 5;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FLUSH      = 3'd1,
    S_SAVE_CAUSE = 3'd2,
    S_SAVE_EPC   = 3'd3,
    S_VECTOR     = 3'd4,
    S_KERNEL     = 3'd5,
    S_RETURN     = 3'd6
  } exc_state_e;

endpackage

// File: rtl/exception_controller_priority_encoder.sv
// Picks the winning exception: highest stage index first, then ovf > ri > syscall
// within a stage. Request bits per stage are packed as {ovf, ri, syscall}.
module exc_priority_encoder
  import exception_controller_pkg::*;
#(
  parameter int NSTAGE = 4,
  parameter int SW     = 2
) (
  input  logic [NSTAGE*3-1:0] exc_req,
  output logic                valid,
  output logic [SW-1:0]       stage,
  output logic [CAUSE_W-1:0]  cause
);

  always_comb begin
    valid = 1'b0;
    stage = '0;
    cause = '0;
    // Ascending scan so that later (older) stages overwrite earlier ones.
    for (int i = 0; i < NSTAGE; i++) begin
      if (|exc_req[i*3 +: 3]) begin
        valid = 1'b1;
        stage = SW'(i);
        if (exc_req[i*3+2])      cause = `INT_OVF;
        else if (exc_req[i*3+1]) cause = `INT_RI;
        else                     cause = `INT_SYSCALL;
      end
    end
  end

endmodule

// File: rtl/exception_controller.sv
// Precise-exception sequencer: flush, save Cause/EPC to CP0, vector to the kernel,
// and return on eret. Define EXC_IRQ_EN to add the external interrupt path.
module exception_controller
  import exception_controller_pkg::*;
#(
  parameter logic [31:0] KERNEL_PC = 32'h80000180,
  parameter int          NSTAGE    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NSTAGE*3-1:0]  exc_req,
  input  logic [NSTAGE*32-1:0] exc_pc,
  input  logic                 eret,
  input  logic [31:0]          epc,
  output logic                 cop_we,
  output logic [4:0]           cop_wreg,
  output logic [31:0]          cop_wdata,
  output logic [NSTAGE-1:0]    flush,
  output logic                 stall,
  output logic                 pc_select,
  output logic [31:0]          pc_target,
  output logic                 in_kernel,
  output logic                 double_fault
`ifdef EXC_IRQ_EN
  ,
  input  logic                 irq,
  input  logic                 sr_ie
`endif
);

  localparam int SW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

  exc_state_e         state_q, state_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic [31:0]        pc_q, pc_d;
  logic [SW-1:0]      stage_q, stage_d;
  logic               double_fault_q, double_fault_d;

  logic               enc_valid;
  logic [SW-1:0]      enc_stage;
  logic [CAUSE_W-1:0] enc_cause;
  logic [31:0]        enc_pc;

  exc_priority_encoder #(
    .NSTAGE (NSTAGE),
    .SW     (SW)
  ) u_prio (
    .exc_req (exc_req),
    .valid   (enc_valid),
    .stage   (enc_stage),
    .cause   (enc_cause)
  );

  always_comb begin
    enc_pc = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (enc_stage == SW'(i)) enc_pc = exc_pc[i*32 +: 32];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cause_q        <= '0;
      pc_q           <= '0;
      stage_q        <= '0;
      double_fault_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cause_q        <= cause_d;
      pc_q           <= pc_d;
      stage_q        <= stage_d;
      double_fault_q <= double_fault_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cause_d        = cause_q;
    pc_d           = pc_q;
    stage_d        = stage_q;
    double_fault_d = double_fault_q;
    cop_we         = 1'b0;
    cop_wreg       = '0;
    cop_wdata      = '0;
    flush          = '0;
    stall          = 1'b0;
    pc_select      = 1'b0;
    pc_target      = '0;
    in_kernel      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enc_valid) begin
          cause_d = enc_cause;
          pc_d    = enc_pc;
          stage_d = enc_stage;
          state_d = S_FLUSH;
        end
`ifdef EXC_IRQ_EN
        // Interrupts attach to the youngest instruction but squash the whole pipe.
        else if (irq && sr_ie) begin
          cause_d = `INT_IRQ;
          pc_d    = exc_pc[31:0];
          stage_d = SW'(NSTAGE - 1);
          state_d = S_FLUSH;
        end
`endif
      end
      S_FLUSH: begin
        for (int i = 0; i < NSTAGE; i++) flush[i] = (SW'(i) <= stage_q);
        stall   = 1'b1;
        state_d = S_SAVE_CAUSE;
      end
      S_SAVE_CAUSE: begin
        cop_we    = 1'b1;
        cop_wreg  = `C0_CAUSE;
        cop_wdata = 32'(cause_q) << `C0_SR_EC;
        stall     = 1'b1;
        state_d   = S_SAVE_EPC;
      end
      S_SAVE_EPC: begin
        cop_we    = 1'b1;
        cop_wreg  = `C0_EPC;
        cop_wdata = pc_q;
        stall     = 1'b1;
        state_d   = S_VECTOR;
      end
      S_VECTOR: begin
        pc_select = 1'b1;
        pc_target = KERNEL_PC;
        flush     = '1;
        state_d   = S_KERNEL;
      end
      S_KERNEL: begin
        in_kernel = 1'b1;
        if (|exc_req) double_fault_d = 1'b1;
        if (eret)     state_d = S_RETURN;
      end
      S_RETURN: begin
        pc_select = 1'b1;
        pc_target = epc;
        flush     = '1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign double_fault = double_fault_q;

endmodule

// File: doc/exception_controller.md
EXCEPTION_CONTROLLER -- requirements
Module: exception_controller

Interface
REQ-001 SHALL have parameter KERNEL_PC, default 32'h80000180, kernel vector address.
REQ-002 SHALL have parameter NSTAGE, default 4, number of pipeline stages reporting exceptions (IF=0, ID=1, EX=2, MEM=3).
REQ-003 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port exc_req  input  NSTAGE*3  per-stage {ovf, ri, syscall} request bits.
REQ-006 SHALL have port exc_pc  input  NSTAGE*32  per-stage instruction PC.
REQ-007 SHALL have port eret  input  1  return-from-exception strobe from ID.
REQ-008 SHALL have port epc  input  32  current C0_EPC value from coprocessor 0.
REQ-009 SHALL have ports cop_we  output  1, cop_wreg  output  5, cop_wdata  output  32: coprocessor 0 write port.
REQ-010 SHALL have port flush  output  NSTAGE  per-stage flush.
REQ-011 SHALL have port stall  output  1  freezes pipeline fetch/advance.
REQ-012 SHALL have ports pc_select  output  1, pc_target  output  32: PC redirect.
REQ-013 SHALL have ports in_kernel  output  1 and double_fault  output  1 (sticky).

Function
REQ-014 SHALL implement states IDLE, FLUSH, SAVE_CAUSE, SAVE_EPC, VECTOR, KERNEL, RETURN.
REQ-015 IDLE: any exc_req bit set -> latch winner's cause code and PC, go FLUSH next edge.
REQ-016 Winner: highest stage index (MEM>EX>ID>IF); within a stage ovf>ri>syscall.
REQ-017 FLUSH (1 cycle): flush[i]=1 for every i <= winning stage; stall=1.
REQ-018 SAVE_CAUSE (1 cycle): cop_we=1, cop_wreg=13, cop_wdata=cause<<`C0_SR_EC; stall=1.
REQ-019 SAVE_EPC (1 cycle): cop_we=1, cop_wreg=14, cop_wdata=latched PC; stall=1.
REQ-020 VECTOR (1 cycle): pc_select=1, pc_target=KERNEL_PC, flush all stages; then KERNEL.
REQ-021 Latency: request sampled at edge N -> pc_select high in cycle N+4 exactly.
REQ-022 KERNEL: in_kernel=1, stall=0; eret -> RETURN.
REQ-023 RETURN (1 cycle): pc_select=1, pc_target=epc, flush all stages; then IDLE.
REQ-024 exc_req while in KERNEL SHALL set double_fault, be otherwise ignored; state unchanged.
REQ-025 exc_req in FLUSH..VECTOR or RETURN SHALL be ignored (sources being flushed).
REQ-026 eret outside KERNEL SHALL be ignored.
REQ-027 Outputs not driven by the current state SHALL be 0; cop_wreg/cop_wdata 0 when cop_we=0.

Reset
REQ-028 reset SHALL force IDLE immediately, any state, mid-sequence included.
REQ-029 Reset values: all outputs 0, latched cause/PC 0, double_fault 0.

Configuration
REQ-030 With EXC_IRQ_EN defined: ports irq input 1 and sr_ie input 1 SHALL exist; in IDLE, irq&&sr_ie with no exc_req SHALL start the sequence with cause `INT_IRQ, PC=exc_pc of IF, flush all stages.
REQ-031 Synchronous exceptions SHALL win over irq in the same cycle.
REQ-032 Without EXC_IRQ_EN: irq/sr_ie ports absent, no interrupt path.

Structure
REQ-033 Cause codes (INT_OVF, INT_RI, INT_SYSCALL, INT_IRQ), C0_* register indices and C0_SR_EC SHALL live in defines.v.
REQ-034 Priority selection SHALL be a sub-module exc_priority_encoder (outputs valid, stage index, cause).

Verification
REQ-035 EX ovf, PC 32'h00400010, at edge N -> flush=4'b0111 cycle N+1; writes (13, `INT_OVF<<`C0_SR_EC) then (14, 32'h00400010); pc_target=32'h80000180 at N+4.
REQ-036 Simultaneous MEM syscall PC 32'h0040002C and ID ri -> MEM syscall wins, EPC 32'h0040002C, flush=4'b1111.
REQ-037 In KERNEL, epc=32'h00400030, eret -> next cycle pc_select=1, pc_target=32'h00400030, then IDLE, in_kernel=0.
REQ-038 exc_req during KERNEL -> double_fault=1 stays until reset, no cop_we.
REQ-039 reset asserted in SAVE_CAUSE -> all outputs 0 same cycle, IDLE after release, no EPC write.
REQ-040 (EXC_IRQ_EN) irq=1, sr_ie=1, IF PC 32'h00400040 -> EPC 32'h00400040, cause `INT_IRQ; sr_ie=0 -> no action.
